branch_ctrl: RTL



---
 rtl/branch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch predictor (direct-mapped BTB + 2-bit counters) and mispredict redirect controller.
// Predicts in IF, resolves and updates in EX, redirects fetch via a valid/ready handshake.
module branch_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int unsigned Entries = 2 ** IDX_W;
    localparam logic [XLEN-1:0] PcInc = XLEN'(4);

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e            state_q, state_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  branches_q, branches_d;
    logic [CNT_W-1:0]  mispredicts_q, mispredicts_d;

    logic              valid_q [Entries];
    logic [TAG_W-1:0]  tag_q   [Entries];
    logic [XLEN-1:0]   tgt_q   [Entries];
    logic [1:0]        cnt_q   [Entries];

    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    logic              if_hit, ex_hit;
    logic              resolve, actual_taken, mispredict;
    logic [XLEN-1:0]   actual_next;

    logic              upd_en;
    logic [1:0]        upd_cnt;
    logic [XLEN-1:0]   upd_tgt;

    // The carried prediction bit is implied by ex_pred_target; only the target is compared.
    logic unused_pred_taken;
    assign unused_pred_taken = ex_pred_taken;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+2 +: TAG_W];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+2 +: TAG_W];

    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && cnt_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + PcInc;

    assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign resolve      = (state_q == StIdle) && ex_valid && (ex_is_branch || ex_is_jump);
    assign actual_taken = ex_is_jump || ex_taken;
    assign actual_next  = actual_taken ? ex_target : ex_pc + PcInc;
    assign mispredict   = actual_next != ex_pred_target;

    always_comb begin
        upd_en  = 1'b0;
        upd_cnt = cnt_q[ex_idx];
        upd_tgt = tgt_q[ex_idx];
        if (resolve) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (actual_taken) begin
                    upd_cnt = (cnt_q[ex_idx] == 2'd3) ? 2'd3 : cnt_q[ex_idx] + 2'd1;
                    upd_tgt = ex_target;
                end else begin
                    upd_cnt = (cnt_q[ex_idx] == 2'd0) ? 2'd0 : cnt_q[ex_idx] - 2'd1;
                end
            end else if (actual_taken) begin
                upd_en  = 1'b1;
                upd_cnt = ex_is_jump ? 2'd3 : 2'd2;
                upd_tgt = ex_target;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        branches_d       = branches_q;
        mispredicts_d    = mispredicts_q;
        unique case (state_q)
            StIdle: begin
                if (resolve) begin
                    branches_d = branches_q + CNT_W'(1);
                    if (mispredict) begin
                        mispredicts_d    = mispredicts_q + CNT_W'(1);
                        redirect_pc_d    = actual_next;
                        redirect_valid_d = 1'b1;
                        flush_d          = 1'b1;
                        state_d          = StRedirect;
                    end
                end
            end
            StRedirect: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            branches_q       <= '0;
            mispredicts_q    <= '0;
            for (int i = 0; i < Entries; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= 2'b01;
            end
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            branches_q       <= branches_d;
            mispredicts_q    <= mispredicts_d;
            if (upd_en) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= upd_tgt;
                cnt_q[ex_idx]   <= upd_cnt;
            end
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = flush_q;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule
